// File: rtl/network_sequencer.sv
// Purpose : sequences samples into a recurrent network core and streams each hidden vector out word by word.
// Latency : accept -> net_newSample 1 cycle; first result word 3 cycles after net_dataReady is first sampled high.
// Backpressure: in_ready only while idle; each out_data word is held stable until out_valid && out_ready.
module network_sequencer #(
    parameter int INPUT_SZ       = 2,
    parameter int HIDDEN_SZ      = 8,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int MAX_SAMPLES    = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int BITWIDTH      = QN + QM + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    // upstream sample interface
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BITWIDTH*INPUT_SZ-1:0]    in_data,
    // network core interface
    output logic                            net_reset,
    output logic                            net_newSample,
    output logic [BITWIDTH*INPUT_SZ-1:0]    net_inputVec,
    input  logic                            net_dataReady,
    input  logic [BITWIDTH*HIDDEN_SZ-1:0]   net_outputVec,
    // downstream result interface
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BITWIDTH-1:0]             out_data,
    output logic                            out_last,
    output logic                            seq_last,
    // status
    output logic                            err
);

    // Counter widths; a single-entry range still needs one bit.
    localparam int IDX_W = (HIDDEN_SZ   > 1) ? $clog2(HIDDEN_SZ)   : 1;
    localparam int CNT_W = (MAX_SAMPLES > 1) ? $clog2(MAX_SAMPLES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HIDDEN_SZ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_SAMPLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        SEQ_RST = 3'd0,
        WAIT_IN = 3'd1,
        PULSE   = 3'd2,
        WAIT_DR = 3'd3,
        SETTLE  = 3'd4,
        STREAM  = 3'd5
    } state_t;

    state_t                          state;
    logic                            rst_cnt;     // which of the two net_reset cycles we are in
    logic                            settle_cnt;  // which of the two settle cycles we are in
    logic                            dr_prev;     // net_dataReady delayed by one cycle
    logic [TO_W-1:0]                 to_cnt;      // cycles spent waiting for the network
    logic [CNT_W-1:0]                sample_cnt;  // position of the current sample in the sequence
    logic [IDX_W-1:0]                index;       // neuron currently presented on out_data
    logic [BITWIDTH*HIDDEN_SZ-1:0]   captured;    // hidden vector frozen for streaming

    logic                            dr_rise;
    logic                            last_sample;
    logic                            out_fire;
    logic [IDX_W-1:0]                next_index;
    logic                            next_is_last;

    // Only a fresh low-to-high transition counts as "result done"; a stale
    // high level left over from the previous sample must not be mistaken for it.
    assign dr_rise      = net_dataReady && !dr_prev;
    assign last_sample  = (sample_cnt == CNT_LAST);
    assign out_fire     = out_valid && out_ready;
    assign next_index   = index + IDX_W'(1);
    assign next_is_last = (next_index == IDX_LAST);

    // Track the previous dataReady level every cycle regardless of state.
    always_ff @(posedge clock) begin
        if (reset) begin
            dr_prev <= 1'b0;
        end else begin
            dr_prev <= net_dataReady;
        end
    end

    // Main sequencer: all handshake and network-control outputs are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= SEQ_RST;
            rst_cnt       <= 1'b0;
            settle_cnt    <= 1'b0;
            to_cnt        <= '0;
            sample_cnt    <= '0;
            index         <= '0;
            captured      <= '0;
            net_reset     <= 1'b1;
            in_ready      <= 1'b0;
            net_newSample <= 1'b0;
            net_inputVec  <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            seq_last      <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                // Hold the network in reset for two cycles, then open for input.
                SEQ_RST: begin
                    sample_cnt <= '0;
                    if (rst_cnt) begin
                        rst_cnt   <= 1'b0;
                        net_reset <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= WAIT_IN;
                    end else begin
                        rst_cnt   <= 1'b1;
                        net_reset <= 1'b1;
                    end
                end

                // Latch one sample; the vector stays put until the next accept.
                WAIT_IN: begin
                    if (in_valid && in_ready) begin
                        net_inputVec  <= in_data;
                        in_ready      <= 1'b0;
                        net_newSample <= 1'b1;
                        state         <= PULSE;
                    end
                end

                // Single-cycle start strobe to the network.
                PULSE: begin
                    net_newSample <= 1'b0;
                    to_cnt        <= '0;
                    state         <= WAIT_DR;
                end

                // Wait for a rising dataReady; give up after TIMEOUT_CYCLES cycles.
                WAIT_DR: begin
                    if (dr_rise) begin
                        to_cnt     <= '0;
                        settle_cnt <= 1'b0;
                        state      <= SETTLE;
                    end else if (to_cnt == TO_LAST) begin
                        to_cnt    <= '0;
                        err       <= 1'b1;
                        net_reset <= 1'b1;
                        rst_cnt   <= 1'b0;
                        state     <= SEQ_RST;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                // Let the hidden vector settle, then freeze it and present neuron 0.
                SETTLE: begin
                    if (!settle_cnt) begin
                        settle_cnt <= 1'b1;
                    end else begin
                        settle_cnt <= 1'b0;
                        captured   <= net_outputVec;
                        index      <= '0;
                        out_valid  <= 1'b1;
                        out_data   <= net_outputVec[BITWIDTH-1:0];
                        out_last   <= (HIDDEN_SZ == 1);
                        seq_last   <= (HIDDEN_SZ == 1) && last_sample;
                        state      <= STREAM;
                    end
                end

                // One neuron per accepted handshake; outputs only move on a handshake.
                STREAM: begin
                    if (out_fire) begin
                        if (index == IDX_LAST) begin
                            index     <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_last  <= 1'b0;
                            seq_last  <= 1'b0;
                            if (last_sample) begin
                                sample_cnt <= '0;
                                net_reset  <= 1'b1;
                                rst_cnt    <= 1'b0;
                                state      <= SEQ_RST;
                            end else begin
                                sample_cnt <= sample_cnt + CNT_W'(1);
                                in_ready   <= 1'b1;
                                state      <= WAIT_IN;
                            end
                        end else begin
                            index    <= next_index;
                            out_data <= captured[next_index*BITWIDTH +: BITWIDTH];
                            out_last <= next_is_last;
                            seq_last <= next_is_last && last_sample;
                        end
                    end
                end

                default: begin
                    net_reset <= 1'b1;
                    rst_cnt   <= 1'b0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    state     <= SEQ_RST;
                end
            endcase
        end
    end

endmodule

// File: doc/network_sequencer.md
NETWORK_SEQUENCER -- requirements
Module: network_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): INPUT_SZ, 2, inputs per sample; HIDDEN_SZ, 8, neurons per result; QN, 6, integer bits; QM, 11, fraction bits; MAX_SAMPLES, 8, samples per sequence; TIMEOUT_CYCLES, 1024, max wait for dataReady; BITWIDTH = QN+QM+1 (derived).
REQ-002 Ports SHALL be (name direction width meaning):
  clock  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-high
  in_valid  in  1  upstream sample valid
  in_ready  out  1  sequencer accepts sample
  in_data  in  BITWIDTH*INPUT_SZ  packed sample, element 0 in LSBs
  net_reset  out  1  reset to network
  net_newSample  out  1  start-of-compute pulse to network
  net_inputVec  out  BITWIDTH*INPUT_SZ  registered sample to network
  net_dataReady  in  1  network result-done level
  net_outputVec  in  BITWIDTH*HIDDEN_SZ  network hidden vector, neuron 0 in LSBs
  out_valid  out  1  result word valid
  out_ready  in  1  downstream accepts word
  out_data  out  BITWIDTH  one neuron value
  out_last  out  1  last neuron of current sample
  seq_last  out  1  last neuron of last sample in sequence
  err  out  1  sticky timeout flag
REQ-003 Clock and reset SHALL be one clock; reset synchronous, active-high.

Function
REQ-004 FSM states SHALL be SEQ_RST, WAIT_IN, PULSE, WAIT_DR, SETTLE, STREAM.
REQ-005 SEQ_RST: net_reset=1 for exactly 2 cycles, then WAIT_IN; sample_cnt cleared.
REQ-006 WAIT_IN: in_ready=1 only here; on in_valid&&in_ready latch in_data into net_inputVec, go PULSE.
REQ-007 PULSE: net_newSample=1 for exactly one cycle, then WAIT_DR; net_inputVec held stable until next accept.
REQ-008 WAIT_DR: advance only on rising edge (net_dataReady=1 and registered previous value=0); a level already high on entry SHALL NOT trigger.
REQ-009 Edge register SHALL update every cycle in all states; cleared to 0 by reset.
REQ-010 SETTLE: 2 cycles; net_outputVec captured into internal register on the 2nd cycle; then STREAM with index 0.
REQ-011 STREAM: out_valid=1; out_data = captured[index*BITWIDTH +: BITWIDTH]; index advances on out_valid&&out_ready; out_data/out_last/seq_last stable while out_valid&&!out_ready.
REQ-012 out_last=1 when index=HIDDEN_SZ-1; seq_last=1 when additionally sample_cnt=MAX_SAMPLES-1.
REQ-013 On handshake of index HIDDEN_SZ-1: if sample_cnt=MAX_SAMPLES-1 go SEQ_RST, else sample_cnt+1 and go WAIT_IN.
REQ-014 Latency: first out_valid SHALL be 3 cycles after the cycle net_dataReady is first sampled high; in_ready to net_newSample 1 cycle.
REQ-015 Timeout: counter counts cycles in WAIT_DR; reaching TIMEOUT_CYCLES sets err=1, go SEQ_RST; counter clears on leaving WAIT_DR.
REQ-016 err SHALL be sticky, cleared only by reset; operation continues after err.
REQ-017 Outputs other than those in the active state SHALL be 0 (in_ready, net_newSample, out_valid, out_last, seq_last).

Reset
REQ-018 On reset: state SEQ_RST, net_reset=1, in_ready=0, net_newSample=0, net_inputVec=0, out_valid=0, out_data=0, out_last=0, seq_last=0, err=0, sample_cnt=0, index=0, timeout counter=0.
REQ-019 Reset asserted mid-operation (any state) SHALL abort in the same cycle and restart at SEQ_RST with REQ-005 timing; captured data discarded.

Verification
REQ-020 Release reset -> net_reset high exactly 2 cycles, in_ready=1 on 3rd cycle, err=0.
REQ-021 Accept in_data={18'h00800,18'h00400}, model dataReady rising 10 cycles after pulse with neurons 0..7 = 1..8, out_ready=1 -> one-cycle net_newSample, net_inputVec=that value, out_data 1..8 on 8 consecutive cycles starting 3 cycles after rise, out_last on value 8.
REQ-022 out_ready alternating 0/1 during STREAM -> each word held until accepted, no loss/duplication, 16 cycles for 8 words.
REQ-023 8 full samples -> seq_last only on 64th word, then net_reset high 2 cycles and sample_cnt=0.
REQ-024 net_dataReady held high across PULSE -> no capture; fall then rise -> capture proceeds normally.
REQ-025 TIMEOUT_CYCLES=16, no dataReady -> err=1 after 16 WAIT_DR cycles, net_reset reasserts; reset pulse during STREAM -> out_valid=0 next cycle, err cleared.
